front_line_buffer: RTL and testbench
====================================

Name: front_line_buffer

Overview:
- Receiving end of the front (sprite) layer pixel stream.
- Accepts the serialized sprite pixels (FD) together with the per-sprite start position (FL_Y).
- Composes one scanline into a 512-entry line buffer while the other buffer is scanned out to the mixer.
- The two 512x8 banks swap at every line strobe. Each location is cleared to transparent as it is read, so the bank is ready to be written again.

Parameters:
- ADDR_WIDTH, 9, line buffer address width (512 entries per bank).
- PIX_W, 8, pixel width (matches FD[7:0]).
- TRANSP, 3'b111, value of pixel bits [2:0] that marks a transparent pixel (not written).
- CLR_VAL, 8'h07, value written on clear and driven on RD_PIX when idle.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- VIDEO_RST  in  1  synchronous, active-high reset.
- LINE_SWAP  in  1  single-cycle strobe at line start; toggles the bank assignment.
- WR_LOAD  in  1  single-cycle strobe; loads the write pointer from WR_POS.
- WR_POS  in  ADDR_WIDTH  sprite start position (FL_Y).
- WR_CEN  in  1  pixel write enable, one per shifted pixel.
- WR_PIX  in  PIX_W  pixel from the front layer (FD).
- RD_CEN  in  1  read enable, one per output pixel.
- RD_ADDR  in  ADDR_WIDTH  scan-out position.
- RD_PIX  out  PIX_W  registered scan-out pixel.
- WR_BANK  out  1  bank currently being written (read bank is ~WR_BANK).
- BUSY  out  1  high while the post-reset clear sweep runs.

Behaviour:
- Storage: two banks of 2^ADDR_WIDTH x PIX_W.
  - Bank WR_BANK is the write bank; bank ~WR_BANK is the read bank.
  - Each bank has one write-side port and one read/clear port.
- Reset (VIDEO_RST high at a clock edge):
  - WR_BANK=0, write pointer wp=0, RD_PIX=CLR_VAL, BUSY=1.
  - Clear counter=0; FSM enters CLEAR.
  - Reset asserted mid-line or mid-clear restarts the clear from address 0.
- FSM states:
  - CLEAR: each cycle writes CLR_VAL to address cnt in both banks, then cnt++.
    - When cnt=511 has been written, go to RUN; BUSY falls on the next edge.
    - BUSY is high for exactly 512 cycles after reset release.
    - In CLEAR, LINE_SWAP, WR_LOAD, WR_CEN and RD_CEN are ignored and RD_PIX holds CLR_VAL.
  - RUN: normal operation, described below. There is no exit except reset.
- Write side (RUN):
  - WR_LOAD: wp <= WR_POS.
  - WR_CEN: if WR_PIX[2:0] != TRANSP, write WR_PIX to bank[WR_BANK][wp]. wp <= wp+1 in either case.
  - wp arithmetic is modulo 512 (511+1 -> 0), so a sprite wraps around the line.
  - WR_LOAD and WR_CEN in the same cycle: the pixel goes to WR_POS and wp <= WR_POS+1.
  - Overlapping sprites: the last write wins.
- Read side (RUN):
  - RD_CEN: RD_PIX <= bank[~WR_BANK][RD_ADDR] (1-cycle latency), and the same location is written with CLR_VAL in the same cycle.
  - The old contents are returned, not CLR_VAL.
  - Without RD_CEN, RD_PIX holds its value.
- Swap (RUN):
  - LINE_SWAP: WR_BANK <= ~WR_BANK; wp is unchanged.
  - Any read or write in the swap cycle uses the pre-swap bank assignment; the new assignment applies from the next cycle.
- Collisions: read and write never touch the same bank, so simultaneous WR_CEN and RD_CEN at equal addresses are independent.

Test Plan:
- Reset release, idle inputs -> BUSY=1 for 512 cycles then 0. RD_PIX=8'h07 throughout. A read of any address after the first swap returns 8'h07.
- WR_LOAD with WR_POS=100, then WR_CEN x4 with pixels 8'h31,8'h37,8'h32,8'h33; LINE_SWAP; reads at 100..103 -> 8'h31, 8'h07, 8'h32, 8'h33 (second pixel transparent, not written). Each RD_PIX appears one cycle after RD_CEN.
- Second read pass of 100..103 after another two swaps, with no writes -> all 8'h07 (clear-on-read verified).
- WR_POS=510, 4 pixels 8'h11..8'h14 -> stored at 510, 511, 0, 1 (wrap).
- LINE_SWAP coincident with WR_CEN (pixel 8'h25 at wp=5) and RD_CEN -> pixel lands in the old write bank. WR_BANK toggles the next cycle. The read in that cycle comes from the old read bank.
- VIDEO_RST pulsed mid-line after writes to 200..210 -> BUSY=1 for 512 cycles, WR_BANK=0. All addresses in both banks read 8'h07 afterwards. Inputs applied during CLEAR have no effect.

Source files
------------

// File: rtl/front_line_buffer.sv
// -----------------------------------------------------------------------------
// front_line_buffer
//   Receiving end of the front (sprite) layer pixel stream. Sprite pixels are
//   composed into one 512-entry bank while the other bank is scanned out to
//   the mixer. The banks swap on every line strobe. Each scanned location is
//   cleared to transparent as it is read, so the bank is ready for reuse.
//   After reset a sweep clears both banks before normal operation starts.
//
// Ports
//   clk        in   system clock (rising edge)
//   VIDEO_RST  in   synchronous active-high reset
//   LINE_SWAP  in   line-start strobe, toggles the bank assignment
//   WR_LOAD    in   loads the write pointer from WR_POS
//   WR_POS     in   sprite start position
//   WR_CEN     in   pixel write enable (advances the write pointer)
//   WR_PIX     in   sprite pixel
//   RD_CEN     in   scan-out read enable (read-and-clear)
//   RD_ADDR    in   scan-out position
//   RD_PIX     out  registered scan-out pixel
//   WR_BANK    out  bank currently written (read bank is ~WR_BANK)
//   BUSY       out  high while the post-reset clear sweep runs
// -----------------------------------------------------------------------------
module front_line_buffer #(
  parameter int               ADDR_WIDTH = 9,
  parameter int               PIX_W      = 8,
  parameter logic [2:0]       TRANSP     = 3'b111,
  parameter logic [PIX_W-1:0] CLR_VAL    = 8'h07
) (
  input  logic                  clk,
  input  logic                  VIDEO_RST,
  input  logic                  LINE_SWAP,
  input  logic                  WR_LOAD,
  input  logic [ADDR_WIDTH-1:0] WR_POS,
  input  logic                  WR_CEN,
  input  logic [PIX_W-1:0]      WR_PIX,
  input  logic                  RD_CEN,
  input  logic [ADDR_WIDTH-1:0] RD_ADDR,
  output logic [PIX_W-1:0]      RD_PIX,
  output logic                  WR_BANK,
  output logic                  BUSY
);

  localparam int                    DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ONE_ADDR  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Low three bits equal to TRANSP mark a pixel that must not be stored.
  function automatic logic is_transparent(input logic [PIX_W-1:0] pix);
    return (pix[2:0] == TRANSP);
  endfunction

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    run_s;
  logic [ADDR_WIDTH-1:0]   cnt_r;
  logic                    busy_r;
  logic [ADDR_WIDTH-1:0]   wp_r;
  logic [ADDR_WIDTH-1:0]   wp_eff_s;
  logic                    wr_bank_r;
  logic                    pix_write_s;
  logic [PIX_W-1:0]        rd_pix_r;

  logic [1:0]              we_s;
  logic [ADDR_WIDTH-1:0]   addr_s [2];
  logic [PIX_W-1:0]        data_s [2];

  logic [PIX_W-1:0]        mem0_r [DEPTH];
  logic [PIX_W-1:0]        mem1_r [DEPTH];

  assign run_s   = (state_r == ST_RUN);
  assign RD_PIX  = rd_pix_r;
  assign WR_BANK = wr_bank_r;
  assign BUSY    = busy_r;

  // Next-state logic: the clear sweep ends after the last address is written.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (cnt_r == LAST_ADDR) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_CLEAR;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_CLEAR;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (VIDEO_RST) begin
      state_r <= ST_CLEAR;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Clear sweep counter and BUSY flag; BUSY drops on the edge writing the last address.
  always_ff @(posedge clk) begin
    if (VIDEO_RST) begin
      cnt_r  <= {ADDR_WIDTH{1'b0}};
      busy_r <= 1'b1;
    end else begin
      if (!run_s) begin
        cnt_r <= cnt_r + ONE_ADDR;
      end
      busy_r <= (state_nxt_s == ST_CLEAR);
    end
  end

  // A load in the same cycle as a pixel redirects that pixel to WR_POS.
  always_comb begin
    wp_eff_s    = WR_LOAD ? WR_POS : wp_r;
    pix_write_s = run_s && WR_CEN && !is_transparent(WR_PIX);
  end

  // Write pointer: wraps modulo the bank depth so sprites wrap around the line.
  always_ff @(posedge clk) begin
    if (VIDEO_RST) begin
      wp_r <= {ADDR_WIDTH{1'b0}};
    end else if (run_s && WR_CEN) begin
      wp_r <= wp_eff_s + ONE_ADDR;
    end else if (run_s && WR_LOAD) begin
      wp_r <= WR_POS;
    end
  end

  // Bank assignment register; the new assignment takes effect the cycle after the strobe.
  always_ff @(posedge clk) begin
    if (VIDEO_RST) begin
      wr_bank_r <= 1'b0;
    end else if (run_s && LINE_SWAP) begin
      wr_bank_r <= ~wr_bank_r;
    end
  end

  // Per-bank write port steering: clear sweep, sprite write, or clear-on-read.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      we_s[b]   = 1'b0;
      addr_s[b] = {ADDR_WIDTH{1'b0}};
      data_s[b] = CLR_VAL;
      if (!run_s) begin
        we_s[b]   = 1'b1;
        addr_s[b] = cnt_r;
        data_s[b] = CLR_VAL;
      end else if (wr_bank_r == 1'(b)) begin
        we_s[b]   = pix_write_s;
        addr_s[b] = wp_eff_s;
        data_s[b] = WR_PIX;
      end else begin
        we_s[b]   = RD_CEN;
        addr_s[b] = RD_ADDR;
        data_s[b] = CLR_VAL;
      end
    end
  end

  // Bank 0 storage.
  always_ff @(posedge clk) begin
    if (we_s[0]) begin
      mem0_r[addr_s[0]] <= data_s[0];
    end
  end

  // Bank 1 storage.
  always_ff @(posedge clk) begin
    if (we_s[1]) begin
      mem1_r[addr_s[1]] <= data_s[1];
    end
  end

  // Scan-out register: returns the old contents of the read bank (clear lands the same edge).
  always_ff @(posedge clk) begin
    if (VIDEO_RST) begin
      rd_pix_r <= CLR_VAL;
    end else if (run_s && RD_CEN) begin
      rd_pix_r <= wr_bank_r ? mem0_r[RD_ADDR] : mem1_r[RD_ADDR];
    end
  end

endmodule

// File: tb/tb_front_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_front_line_buffer
//   Self-checking bench for front_line_buffer. A behavioural model (two plain
//   arrays, a pointer and a clear-countdown) predicts every output after each
//   clock edge; directed sequences add literal expectations, then randomized
//   traffic runs against the same model.
// -----------------------------------------------------------------------------
module tb_front_line_buffer;

  logic       clk = 1'b0;
  logic       VIDEO_RST, LINE_SWAP, WR_LOAD, WR_CEN, RD_CEN;
  logic [8:0] WR_POS, RD_ADDR;
  logic [7:0] WR_PIX;
  logic [7:0] RD_PIX;
  logic       WR_BANK, BUSY;

  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model state.
  logic [7:0] mb [2][512];
  int         m_wb, m_wp, m_busy_left;
  logic [7:0] m_rd;
  bit         m_valid = 1'b0;

  front_line_buffer dut (
    .clk(clk), .VIDEO_RST(VIDEO_RST), .LINE_SWAP(LINE_SWAP),
    .WR_LOAD(WR_LOAD), .WR_POS(WR_POS), .WR_CEN(WR_CEN), .WR_PIX(WR_PIX),
    .RD_CEN(RD_CEN), .RD_ADDR(RD_ADDR), .RD_PIX(RD_PIX),
    .WR_BANK(WR_BANK), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply the rules of one clock edge to the model using the current inputs.
  task automatic model_edge();
    int p;
    int wb;
    if (VIDEO_RST) begin
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 512; a++) mb[b][a] = 8'h07;
      m_wb = 0; m_wp = 0; m_rd = 8'h07; m_busy_left = 512; m_valid = 1'b1;
    end else if (m_busy_left > 0) begin
      m_busy_left--;
    end else begin
      wb = m_wb;
      if (RD_CEN) begin
        m_rd = mb[1-wb][RD_ADDR];
        mb[1-wb][RD_ADDR] = 8'h07;
      end
      p = WR_LOAD ? int'(WR_POS) : m_wp;
      if (WR_CEN) begin
        if (WR_PIX[2:0] != 3'b111) mb[wb][p] = WR_PIX;
        m_wp = (p + 1) % 512;
      end else if (WR_LOAD) begin
        m_wp = int'(WR_POS);
      end
      if (LINE_SWAP) m_wb = 1 - wb;
    end
  endtask

  // One clock: model update, edge, then compare all outputs against the model.
  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    if (m_valid) begin
      chk("RD_PIX", {24'd0, RD_PIX}, {24'd0, m_rd});
      chk("WR_BANK", {31'd0, WR_BANK}, m_wb[31:0] & 32'd1);
      chk("BUSY", {31'd0, BUSY}, (m_busy_left > 0) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic idle();
    VIDEO_RST = 1'b0; LINE_SWAP = 1'b0; WR_LOAD = 1'b0; WR_CEN = 1'b0; RD_CEN = 1'b0;
    WR_POS = 9'd0; RD_ADDR = 9'd0; WR_PIX = 8'h00;
  endtask

  task automatic rand_inputs(input bit allow_rst);
    VIDEO_RST = allow_rst && ($urandom_range(0, 1999) == 0);
    LINE_SWAP = ($urandom_range(0, 63) == 0);
    WR_LOAD   = ($urandom_range(0, 15) == 0);
    WR_CEN    = $urandom_range(0, 1) == 1;
    RD_CEN    = $urandom_range(0, 1) == 1;
    WR_POS    = 9'($urandom_range(0, 511));
    RD_ADDR   = 9'($urandom_range(0, 511));
    WR_PIX    = 8'($urandom_range(0, 255));
  endtask

  // Count edges until BUSY falls (bounded), optionally with random inputs during the sweep.
  task automatic wait_clear(input bit noisy, output int n);
    n = 0;
    while (BUSY === 1'b1 && n < 600) begin
      if (noisy) rand_inputs(1'b0); else idle();
      step();
      n++;
    end
    idle();
  endtask

  task automatic rd(input logic [8:0] a);
    idle(); RD_CEN = 1'b1; RD_ADDR = a; step(); idle();
  endtask

  task automatic wr(input logic [7:0] pix);
    idle(); WR_CEN = 1'b1; WR_PIX = pix; step(); idle();
  endtask

  task automatic swap();
    idle(); LINE_SWAP = 1'b1; step(); idle();
  endtask

  logic [7:0] exp_a [4];
  logic [7:0] exp_b [4];
  logic [8:0] wrap_addr [4];
  int n;

  initial begin
    exp_a = '{8'h31, 8'h07, 8'h32, 8'h33};
    exp_b = '{8'h11, 8'h12, 8'h13, 8'h14};
    wrap_addr = '{9'd510, 9'd511, 9'd0, 9'd1};
    idle();
    // Reset and clear sweep.
    VIDEO_RST = 1'b1; step(); step(); idle();
    chk("rst_busy", {31'd0, BUSY}, 32'd1);
    chk("rst_rdpix", {24'd0, RD_PIX}, 32'h07);
    chk("rst_bank", {31'd0, WR_BANK}, 32'd0);
    wait_clear(1'b0, n);
    chk("busy_cycles", n, 32'd512);
    swap();
    chk("bank_after_swap", {31'd0, WR_BANK}, 32'd1);
    rd(9'd37);
    chk("fresh_read", {24'd0, RD_PIX}, 32'h07);

    // Sprite with a transparent pixel.
    idle(); WR_LOAD = 1'b1; WR_POS = 9'd100; step(); idle();
    wr(8'h31); wr(8'h37); wr(8'h32); wr(8'h33);
    swap();
    for (int i = 0; i < 4; i++) begin
      rd(9'(100 + i));
      chk("sprite_read", {24'd0, RD_PIX}, {24'd0, exp_a[i]});
    end

    // Clear-on-read: second pass after two swaps.
    swap(); swap();
    for (int i = 0; i < 4; i++) begin
      rd(9'(100 + i));
      chk("cleared_read", {24'd0, RD_PIX}, 32'h07);
    end

    // Wrap around the end of the line, load coincident with the first pixel.
    idle(); WR_LOAD = 1'b1; WR_POS = 9'd510; WR_CEN = 1'b1; WR_PIX = 8'h11; step(); idle();
    wr(8'h12); wr(8'h13); wr(8'h14);
    swap();
    for (int i = 0; i < 4; i++) begin
      rd(wrap_addr[i]);
      chk("wrap_read", {24'd0, RD_PIX}, {24'd0, exp_b[i]});
    end

    // Swap coincident with a write and a read.
    idle(); WR_LOAD = 1'b1; WR_POS = 9'd5; step(); idle();
    chk("pre_swap_bank", {31'd0, WR_BANK}, 32'd1);
    LINE_SWAP = 1'b1; WR_CEN = 1'b1; WR_PIX = 8'h25; RD_CEN = 1'b1; RD_ADDR = 9'd5;
    step(); idle();
    chk("swap_cycle_read", {24'd0, RD_PIX}, 32'h07);
    chk("post_swap_bank", {31'd0, WR_BANK}, 32'd0);
    rd(9'd5);
    chk("old_wbank_pixel", {24'd0, RD_PIX}, 32'h25);

    // Writes mid-line, then reset with noisy inputs during the sweep.
    idle(); WR_LOAD = 1'b1; WR_POS = 9'd200; step(); idle();
    for (int i = 0; i < 11; i++) wr(8'h40 + 8'(i));
    VIDEO_RST = 1'b1; step(); idle();
    wait_clear(1'b1, n);
    chk("busy_cycles_2", n, 32'd512);
    chk("bank_after_rst", {31'd0, WR_BANK}, 32'd0);
    for (int b = 0; b < 2; b++) begin
      for (int a = 0; a < 512; a++) begin
        rd(9'(a));
        chk("post_rst_read", {24'd0, RD_PIX}, 32'h07);
      end
      swap();
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 4000; i++) begin
      rand_inputs(1'b1);
      step();
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
